// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// hex font and the dark digit-enable level.
package seg_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Entry n is the a..g pattern for hex digit n (bit 0 = a).
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic SEG_EN_IDLE = 1'b1;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment (a..g) pattern.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_FONT[nibble];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with gap, leading-zero blanking
// and optional blinking (compiled in when SEG_BLINK_EN is defined).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned BLINK_DIV   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [7:0]            digital_light,
    output logic [DIGITS-1:0]     seg_en
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [7:0]          light_q, light_d;
    logic [DIGITS-1:0]   seg_en_q, seg_en_d;

    logic [3:0] nib;
    logic [6:0] font_seg;
    logic       dp_cur;
    logic       upper_zero;
    logic       blink_now;
    logic       slot_wrap;

    seg7_decode u_dec (
        .nibble (nib),
        .seg    (font_seg)
    );

    always_comb begin
        slot_wrap = (cnt_q == CNT_MAX);
        cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        value_d = load ? value   : value_q;
        dp_d    = load ? dp_mask : dp_q;
    end

    // Select the current digit and check whether it and every higher digit are zero.
    always_comb begin
        nib        = '0;
        dp_cur     = 1'b0;
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i == 32'(idx_q)) begin
                nib    = value_q[4*i +: 4];
                dp_cur = dp_q[i];
            end
            if ((i >= 32'(idx_q)) && (value_q[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              boff_q, boff_d;
    logic [DIGITS-1:0] blink_q, blink_d;
    logic              frame_done;
    logic              blink_sel;

    always_comb begin
        frame_done = slot_wrap && (idx_q == IDX_MAX);
        bcnt_d     = bcnt_q;
        boff_d     = boff_q;
        blink_d    = load ? blink_mask : blink_q;
        if (frame_done) begin
            if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                bcnt_d = '0;
                boff_d = ~boff_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
        blink_sel = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i == 32'(idx_q)) begin
                blink_sel = blink_q[i];
            end
        end
        blink_now = boff_q & blink_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q  <= '0;
            boff_q  <= 1'b0;
            blink_q <= '0;
        end else begin
            bcnt_q  <= bcnt_d;
            boff_q  <= boff_d;
            blink_q <= blink_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blink_now    = 1'b0;
`endif

    // Priority: gap, then blink, then leading-zero blanking, then plain decode.
    always_comb begin
        seg_en_d = {DIGITS{SEG_EN_IDLE}};
        light_d  = '0;
        if (cnt_q >= GAP_END) begin
            seg_en_d = ~(DIGITS'(1) << idx_q);
            if (!blink_now) begin
                light_d[SEG_DP] = dp_cur;
                if (!(blank_lz && (idx_q != '0) && upper_zero)) begin
                    light_d[SEG_G:SEG_A] = font_seg;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            value_q  <= '0;
            dp_q     <= '0;
            light_q  <= '0;
            seg_en_q <= {DIGITS{SEG_EN_IDLE}};
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            dp_q     <= dp_d;
            light_q  <= light_d;
            seg_en_q <= seg_en_d;
        end
    end

    assign digital_light = light_q;
    assign seg_en        = seg_en_q;

endmodule
